// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file writeback controller.
//   WIDTH      : register data width in bits
//   DEPTH      : number of architectural registers
//   REG_ADDR_W : register address width, $clog2(DEPTH)
//   reg_addr_t : register address type
//   wb_req_t   : one writeback request {valid, rd, data}
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int WIDTH      = 32;
    localparam int DEPTH      = 32;
    localparam int REG_ADDR_W = $clog2(DEPTH);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic             valid;
        reg_addr_t        rd;
        logic [WIDTH-1:0] data;
    } wb_req_t;

endpackage : regfile_pkg

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter with a grant that is independent of the
// requester's own request bit, so it can be used directly as a ready signal.
//   clk   in   clock
//   rst   in   asynchronous reset, active high
//   req   in   [1:0] request bits (bit 0 = ALU, bit 1 = LSU)
//   grant out  [1:0] grant / ready bits
// grant[i] is 1 whenever the other side is idle, or when both compete and
// side i holds priority. grant & req is therefore at most one-hot.
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // 1: requester 0 wins the next conflict, 0: requester 1 wins it.
    logic prio0_q;

    assign grant[0] = ~req[1] |  prio0_q;
    assign grant[1] = ~req[0] | ~prio0_q;

    // A conflict always ends in a transfer for the favoured side (its grant
    // does not depend on anything else), so the pointer flips on every
    // conflict and the loser is favoured next time.
    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio0_q <= 1'b1;
        end else if (&req) begin
            prio0_q <= ~prio0_q;
        end
    end

endmodule : rr_arbiter2

// File: rtl/regfile_wb_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_wb_ctrl
// Register-file writeback controller with a pending-write scoreboard.
// Arbitrates ALU and LSU writeback results onto a single registered write
// port, tracks outstanding destination registers, and reports RAW hazards
// (decode stall) and WAW blocking (issue_ready).
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   issue_valid/issue_rd       instruction issuing with destination issue_rd
//   issue_ready                0 while issue_rd already has a write pending
//   rs1, rs2                   decode source operands
//   hazard                     a nonzero source has a write pending
//   alu_valid/rd/data/ready    ALU writeback handshake
//   lsu_valid/rd/data/ready    LSU writeback handshake
//   write_en, rd, write_data   registered register-file write port
//   pending                    scoreboard bitmap, bit n = write to xn pending
// -----------------------------------------------------------------------------
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter  int WIDTH = regfile_pkg::WIDTH,
    parameter  int DEPTH = regfile_pkg::DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_ready,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    output logic             hazard,

    input  logic             alu_valid,
    input  logic [AW-1:0]    alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    output logic             alu_ready,
    input  logic             lsu_valid,
    input  logic [AW-1:0]    lsu_rd,
    input  logic [WIDTH-1:0] lsu_data,
    output logic             lsu_ready,

    output logic             write_en,
    output logic [AW-1:0]    rd,
    output logic [WIDTH-1:0] write_data,
    output logic [DEPTH-1:0] pending
);

    // ------------------------------------------------------------------
    // Writeback arbitration
    // ------------------------------------------------------------------
    logic [1:0]       wb_grant;
    logic             alu_fire;
    logic             lsu_fire;
    logic             wb_fire;
    logic [AW-1:0]    wb_rd;
    logic [WIDTH-1:0] wb_data;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({lsu_valid, alu_valid}),
        .grant (wb_grant)
    );

    assign alu_ready = wb_grant[0];
    assign lsu_ready = wb_grant[1];
    assign alu_fire  = alu_valid & alu_ready;
    assign lsu_fire  = lsu_valid & lsu_ready;
    assign wb_fire   = alu_fire | lsu_fire;

    // At most one of alu_fire / lsu_fire is set, so a simple select works.
    assign wb_rd   = lsu_fire ? lsu_rd   : alu_rd;
    assign wb_data = lsu_fire ? lsu_data : alu_data;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic             issue_fire;

    // pending_q[0] is held at 0, so x0 never blocks; the explicit rd!=0 term
    // keeps the intent readable.
    assign issue_ready = (issue_rd == '0) | ~pending_q[issue_rd];
    assign issue_fire  = issue_valid & issue_ready & (issue_rd != '0);

    // Registered bits only: a result written this cycle clears the hazard
    // from the next cycle on.
    assign hazard = ((rs1 != '0) & pending_q[rs1]) |
                    ((rs2 != '0) & pending_q[rs2]);

    // Clear first, then set: an issue to a register whose bit is already
    // clear still wins when the same edge writes that register back.
    // NOTE: combinational blocks assign a default first so every path drives
    // every output and no latch is inferred.
    always_comb begin
        pending_d = pending_q;
        if (wb_fire) begin
            pending_d[wb_rd] = 1'b0;
        end
        if (issue_fire) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

    // ------------------------------------------------------------------
    // Registered write port
    // ------------------------------------------------------------------
    // A transfer to x0 completes the handshake and updates rd/write_data,
    // but never strobes write_en. Without a transfer rd/write_data hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_en   <= 1'b0;
            rd         <= '0;
            write_data <= '0;
        end else if (wb_fire) begin
            write_en   <= (wb_rd != '0);
            rd         <= wb_rd;
            write_data <= wb_data;
        end else begin
            write_en   <= 1'b0;
        end
    end

endmodule : regfile_wb_ctrl

// File: tb/tb_regfile_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_ctrl
// Directed self-checking bench for regfile_wb_ctrl. Expected writes are
// pushed to a scoreboard queue (with the cycle they must appear in) when a
// handshake is seen, and a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_regfile_wb_ctrl;
    import regfile_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             issue_valid = 1'b0;
    logic [4:0]       issue_rd    = '0;
    logic             issue_ready;
    logic [4:0]       rs1 = '0;
    logic [4:0]       rs2 = '0;
    logic             hazard;
    logic             alu_valid = 1'b0;
    logic [4:0]       alu_rd    = '0;
    logic [31:0]      alu_data  = '0;
    logic             alu_ready;
    logic             lsu_valid = 1'b0;
    logic [4:0]       lsu_rd    = '0;
    logic [31:0]      lsu_data  = '0;
    logic             lsu_ready;
    logic             write_en;
    logic [4:0]       rd;
    logic [31:0]      write_data;
    logic [31:0]      pending;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;

    wb_req_t exp_q[$];
    int      exp_cyc_q[$];

    regfile_wb_ctrl #(.WIDTH(32), .DEPTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard      (hazard),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .write_en    (write_en),
        .rd          (rd),
        .write_data  (write_data),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Scoreboard monitor: an expected write must appear exactly in its cycle;
    // any other write strobe is unexpected.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_cyc_q[0] == cycle_cnt) begin
                wb_req_t e;
                int      c;
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                checks++;
                if (write_en !== 1'b1 || rd !== e.rd || write_data !== e.data) begin
                    errors++;
                    $display("FAIL wb_write cyc=%0d: got en=%b rd=%0d data=%h, expected en=1 rd=%0d data=%h",
                             c, write_en, rd, write_data, e.rd, e.data);
                end
            end else if (write_en !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected cyc=%0d: got en=%b rd=%0d data=%h, expected en=0",
                         cycle_cnt, write_en, rd, write_data);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [4:0] r, input logic [31:0] d);
        wb_req_t e;
        e.valid = 1'b1;
        e.rd    = r;
        e.data  = d;
        exp_q.push_back(e);
        exp_cyc_q.push_back(cycle_cnt + 1);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (write_en !== 1'b0 || rd !== 5'd0 || write_data !== 32'd0 || pending !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got en=%b rd=%0d data=%h pending=%h, expected 0/0/0/0",
                     write_en, rd, write_data, pending);
        end
        checks++;
        if (hazard !== 1'b0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: got hazard=%b issue_ready=%b, expected 0/1", hazard, issue_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        next_cycle();
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'd4;
        @(negedge clk);
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got alu_ready=%b, expected 1", alu_ready);
        end
        expect_write(5'd2, 32'd4);
        next_cycle();
        alu_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_conflict();
        next_cycle();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'd7;
        lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'd9;
        @(negedge clk);
        checks++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL conflict_first: got alu_ready=%b lsu_ready=%b, expected 1/0", alu_ready, lsu_ready);
        end
        expect_write(5'd3, 32'd7);
        next_cycle();
        @(negedge clk);
        checks++;
        if (alu_ready !== 1'b0 || lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL conflict_second: got alu_ready=%b lsu_ready=%b, expected 0/1", alu_ready, lsu_ready);
        end
        expect_write(5'd5, 32'd9);
        next_cycle();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_x0();
        next_cycle();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got lsu_ready=%b, expected 1", lsu_ready);
        end
        next_cycle();
        lsu_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (write_en !== 1'b0 || pending[0] !== 1'b0) begin
            errors++;
            $display("FAIL x0_suppress: got write_en=%b pending0=%b, expected 0/0", write_en, pending[0]);
        end
    endtask

    task automatic test_raw();
        next_cycle();
        issue_valid = 1'b1; issue_rd = 5'd6; rs1 = 5'd6; rs2 = 5'd0;
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b1 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL raw_issue: got issue_ready=%b hazard=%b, expected 1/0", issue_ready, hazard);
        end
        next_cycle();
        issue_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pending[6] !== 1'b1 || hazard !== 1'b1) begin
            errors++;
            $display("FAIL raw_stall_rs1: got pending6=%b hazard=%b, expected 1/1", pending[6], hazard);
        end
        next_cycle();
        rs1 = 5'd0; rs2 = 5'd6;
        @(negedge clk);
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL raw_stall_rs2: got hazard=%b, expected 1", hazard);
        end
        next_cycle();
        rs1 = 5'd6; rs2 = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h0000_0066;
        @(negedge clk);
        checks++;
        if (alu_ready !== 1'b1 || hazard !== 1'b1) begin
            errors++;
            $display("FAIL raw_wb_cycle: got alu_ready=%b hazard=%b, expected 1/1", alu_ready, hazard);
        end
        expect_write(5'd6, 32'h0000_0066);
        next_cycle();
        alu_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (hazard !== 1'b0 || pending[6] !== 1'b0) begin
            errors++;
            $display("FAIL raw_release: got hazard=%b pending6=%b, expected 0/0", hazard, pending[6]);
        end
        rs1 = 5'd0;
    endtask

    task automatic test_waw();
        next_cycle();
        issue_valid = 1'b1; issue_rd = 5'd8;
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL waw_first_issue: got issue_ready=%b, expected 1", issue_ready);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b0 || pending[8] !== 1'b1) begin
            errors++;
            $display("FAIL waw_block: got issue_ready=%b pending8=%b, expected 0/1", issue_ready, pending[8]);
        end
        next_cycle();
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h0000_0088;
        @(negedge clk);
        checks++;
        if (lsu_ready !== 1'b1 || issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL waw_wb_cycle: got lsu_ready=%b issue_ready=%b, expected 1/0", lsu_ready, issue_ready);
        end
        expect_write(5'd8, 32'h0000_0088);
        next_cycle();
        lsu_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b1 || pending[8] !== 1'b0) begin
            errors++;
            $display("FAIL waw_release: got issue_ready=%b pending8=%b, expected 1/0", issue_ready, pending[8]);
        end
        // issue_valid is still high for x8, so the next edge re-marks it.
    endtask

    task automatic test_reset_mid();
        // Issue x2 while the ALU writes x9 (bit already clear) and the LSU
        // competes; the ALU holds priority here, so the pointer moves to LSU.
        next_cycle();
        issue_rd = 5'd2;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'h0000_00CC;
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b1 || alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_setup: got issue_ready=%b alu_ready=%b lsu_ready=%b, expected 1/1/0",
                     issue_ready, alu_ready, lsu_ready);
        end
        expect_write(5'd9, 32'h0000_0099);
        next_cycle();
        issue_valid = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pending !== 32'h0000_0104 || write_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_prestate: got pending=%h write_en=%b, expected 00000104/1", pending, write_en);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (pending !== 32'd0 || write_en !== 1'b0 || rd !== 5'd0 || write_data !== 32'd0) begin
            errors++;
            $display("FAIL mid_async_reset: got pending=%h en=%b rd=%0d data=%h, expected 0/0/0/0",
                     pending, write_en, rd, write_data);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        // Pointer must favour the ALU again after reset.
        next_cycle();
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_00AA;
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'h0000_00BB;
        @(negedge clk);
        checks++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rr_reset: got alu_ready=%b lsu_ready=%b, expected 1/0", alu_ready, lsu_ready);
        end
        expect_write(5'd10, 32'h0000_00AA);
        next_cycle();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_conflict();
        test_x0();
        test_raw();
        test_waw();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding writes, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile_wb_ctrl
